// File: rtl/icache_lookup_pkg.sv
// icache_lookup_pkg
//   Shared definitions for the instruction-cache lookup stage: the lookup
//   controller state encoding and the default cache geometry used when the
//   top level is instantiated without overrides.
//   No ports (package).
package icache_lookup_pkg;

  localparam int ADDR_W          = 32;
  localparam int DEF_WAYS        = 8;
  localparam int DEF_SETS        = 8;
  localparam int DEF_BLOCK_BYTES = 16;

  typedef enum logic [1:0] {
    ICL_IDLE   = 2'b00,
    ICL_LOOKUP = 2'b01,
    ICL_INVAL  = 2'b10
  } icl_state_e;

endpackage

// File: rtl/icache_lookup_plru.sv
// icache_plru
//   Purely combinational tree-PLRU helper for one cache set.
//   Tree bits are stored heap-style: node n (1..WAYS-1) lives at bit n-1,
//   its children are nodes 2n and 2n+1. A bit value of 0 means the victim
//   lies in the left (lower-numbered) subtree, 1 means the right subtree.
//   Ports:
//     bits      in  WAYS-1 : current tree bits of the set
//     way       in  WAY_W  : way being accessed (hit or refill)
//     victim    out WAY_W  : way selected by walking the tree
//     next_bits out WAYS-1 : tree bits after touching `way`
module icache_plru
  import icache_lookup_pkg::*;
#(
  parameter  int WAYS  = DEF_WAYS,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-2:0]  bits,
  input  logic [WAY_W-1:0] way,
  output logic [WAY_W-1:0] victim,
  output logic [WAYS-2:0]  next_bits
);

  // Follow the tree from the root; after WAY_W steps the node number is
  // WAYS + victim, so its low bits are the victim way.
  always_comb begin : victim_walk
    logic [WAY_W:0] node;
    node = (WAY_W+1)'(1);
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      node = {node[WAY_W-1:0], bits[WAY_W'(node - 1'b1)]};
    end
    victim = node[WAY_W-1:0];
  end

  // Walk the path of the accessed way (MSB first) and point every node on
  // that path at the opposite subtree.
  always_comb begin : update_walk
    logic [WAY_W:0]   node;
    logic [WAY_W-1:0] rest;
    logic             dir;
    next_bits = bits;
    node      = (WAY_W+1)'(1);
    rest      = way;
    dir       = 1'b0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      dir                                = rest[WAY_W-1];
      next_bits[WAY_W'(node - 1'b1)]     = ~dir;
      node                               = {node[WAY_W-1:0], dir};
      rest                               = rest << 1;
    end
  end

endmodule

// File: rtl/icache_lookup.sv
// icache_lookup
//   Lookup stage of the fetch-path instruction cache. Holds one fetch
//   request, compares its tag against every way of the indexed set and
//   presents hit flag, hit way, line data and a tree-PLRU victim. Accepts one
//   request per cycle when downstream is ready. Also runs a SETS-cycle
//   whole-cache invalidation (fence.i).
//   Ports:
//     clock, reset (async, active-low)
//     valid_pre_i / ready_pre_o    : upstream request handshake
//     valid_post_o / ready_post_i  : downstream result handshake
//     flush_i, csr_flush_i         : drop the held request
//     inval_i / inval_busy_o       : start / status of whole-cache invalidation
//     pvalid_i, ptaken_i, ptarget_i, araddr_i : request payload
//     pvalid_o, ptaken_o, ptarget_o, araddr_o : registered payload
//     wen_i, windex_i, wway_i, wtag_i, wdata_i : refill write port
//     tar_hit_o, hit_way_o, buffer_o, victim_o : lookup result (zero outside LOOKUP)
module icache_lookup
  import icache_lookup_pkg::*;
#(
  parameter  int WAYS        = DEF_WAYS,
  parameter  int SETS        = DEF_SETS,
  parameter  int BLOCK_BYTES = DEF_BLOCK_BYTES,
  localparam int OFF_W       = $clog2(BLOCK_BYTES),
  localparam int IDX_W       = $clog2(SETS),
  localparam int WAY_W       = $clog2(WAYS),
  localparam int TAG_W       = ADDR_W - IDX_W - OFF_W,
  localparam int LINE_W      = 8 * BLOCK_BYTES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_pre_i,
  output logic              ready_pre_o,
  output logic              valid_post_o,
  input  logic              ready_post_i,
  input  logic              flush_i,
  input  logic              csr_flush_i,
  input  logic              inval_i,
  output logic              inval_busy_o,
  input  logic              pvalid_i,
  input  logic              ptaken_i,
  input  logic [ADDR_W-1:0] ptarget_i,
  input  logic [ADDR_W-1:0] araddr_i,
  output logic              pvalid_o,
  output logic              ptaken_o,
  output logic [ADDR_W-1:0] ptarget_o,
  output logic [ADDR_W-1:0] araddr_o,
  input  logic              wen_i,
  input  logic [IDX_W-1:0]  windex_i,
  input  logic [WAY_W-1:0]  wway_i,
  input  logic [TAG_W-1:0]  wtag_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic              tar_hit_o,
  output logic [WAY_W-1:0]  hit_way_o,
  output logic [LINE_W-1:0] buffer_o,
  output logic [WAY_W-1:0]  victim_o
);

  icl_state_e state, state_next;
  logic [IDX_W-1:0] icnt;

  logic              pvalid_q, ptaken_q;
  logic [ADDR_W-1:0] ptarget_q, araddr_q;

  logic [SETS-1:0][WAYS-1:0] val;
  logic [SETS-1:0][WAYS-2:0] plru;
  logic [TAG_W-1:0]          tag_mem [SETS][WAYS];
  logic [LINE_W-1:0]         dat_mem [SETS][WAYS];

  logic             flush, lookup, hit, accept_hit, lookup_update, refill_en;
  logic             load, clear_pay;
  logic [IDX_W-1:0] held_idx;
  logic [TAG_W-1:0] held_tag;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] lk_victim, unused_refill_victim;
  logic [WAYS-2:0]  lk_next, rf_next;

  assign flush    = flush_i | csr_flush_i;
  assign lookup   = (state == ICL_LOOKUP);
  assign held_idx = araddr_q[OFF_W +: IDX_W];
  assign held_tag = araddr_q[ADDR_W-1 -: TAG_W];

  // A hit is only "consumed" (and therefore trains the PLRU) when the result
  // actually leaves the stage and nothing is redirecting the pipe this cycle.
  assign accept_hit    = lookup & ready_post_i & hit;
  assign lookup_update = accept_hit & ~flush & ~inval_i;
  assign refill_en     = wen_i & (state != ICL_INVAL);

  // Tag compare across all ways; scanning downwards lets the lowest
  // matching way win if the same tag was ever refilled twice in a set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (val[held_idx][w] && (tag_mem[held_idx][w] == held_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  icache_plru #(.WAYS(WAYS)) u_plru_lookup (
    .bits      (plru[held_idx]),
    .way       (hit_way),
    .victim    (lk_victim),
    .next_bits (lk_next)
  );

  icache_plru #(.WAYS(WAYS)) u_plru_refill (
    .bits      (plru[windex_i]),
    .way       (wway_i),
    .victim    (unused_refill_victim),
    .next_bits (rf_next)
  );

  // Next-state and handshake decode. Invalidation outranks flush, and
  // neither can interrupt an invalidation already in progress.
  always_comb begin
    state_next   = state;
    ready_pre_o  = 1'b0;
    valid_post_o = 1'b0;
    inval_busy_o = 1'b0;
    load         = 1'b0;
    clear_pay    = 1'b0;
    case (state)
      ICL_IDLE: begin
        ready_pre_o = 1'b1;
        if (valid_pre_i) begin
          load       = 1'b1;
          state_next = ICL_LOOKUP;
        end
      end
      ICL_LOOKUP: begin
        valid_post_o = 1'b1;
        ready_pre_o  = ready_post_i;
        if (ready_post_i) begin
          if (valid_pre_i) begin
            load = 1'b1;
          end else begin
            state_next = ICL_IDLE;
          end
        end
      end
      ICL_INVAL: begin
        inval_busy_o = 1'b1;
        if (icnt == IDX_W'(SETS - 1)) begin
          state_next = ICL_IDLE;
        end
      end
      default: state_next = ICL_IDLE;
    endcase
    if (state != ICL_INVAL) begin
      if (inval_i) begin
        state_next = ICL_INVAL;
        load       = 1'b0;
        clear_pay  = 1'b1;
      end else if (flush) begin
        state_next = ICL_IDLE;
        load       = 1'b0;
        clear_pay  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ICL_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The sweep counter sits at zero whenever we are not invalidating, so
  // entering INVAL always starts the sweep at set 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      icnt <= '0;
    end else if (state == ICL_INVAL) begin
      icnt <= icnt + 1'b1;
    end else begin
      icnt <= '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pvalid_q  <= 1'b0;
      ptaken_q  <= 1'b0;
      ptarget_q <= '0;
      araddr_q  <= '0;
    end else if (clear_pay) begin
      pvalid_q  <= 1'b0;
      ptaken_q  <= 1'b0;
      ptarget_q <= '0;
      araddr_q  <= '0;
    end else if (load) begin
      pvalid_q  <= pvalid_i;
      ptaken_q  <= ptaken_i;
      ptarget_q <= ptarget_i;
      araddr_q  <= araddr_i;
    end
  end

  // Valid and PLRU state. The refill update is written after the hit update
  // so that, when both land on the same set, the refill's tree wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      val  <= '0;
      plru <= '0;
    end else if (state == ICL_INVAL) begin
      val[icnt]  <= '0;
      plru[icnt] <= '0;
    end else begin
      if (lookup_update) begin
        plru[held_idx] <= lk_next;
      end
      if (refill_en) begin
        val[windex_i][wway_i] <= 1'b1;
        plru[windex_i]        <= rf_next;
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clock) begin
    if (refill_en) begin
      tag_mem[windex_i][wway_i] <= wtag_i;
      dat_mem[windex_i][wway_i] <= wdata_i;
    end
  end

  assign pvalid_o  = pvalid_q;
  assign ptaken_o  = ptaken_q;
  assign ptarget_o = ptarget_q;
  assign araddr_o  = araddr_q;

  assign tar_hit_o = lookup & hit;
  assign hit_way_o = lookup ? hit_way : '0;
  assign buffer_o  = (lookup && hit) ? dat_mem[held_idx][hit_way] : '0;
  assign victim_o  = lookup ? lk_victim : '0;

endmodule

// File: tb/tb_icache_lookup.sv
// tb_icache_lookup
//   Self-checking bench for icache_lookup. A stimulus process drives one
//   cycle at a time and keeps a behavioural cache model; the expected
//   per-cycle handshake state and every expected accepted result are queued,
//   and an independent monitor pops and compares them against the DUT.
module tb_icache_lookup;
  import icache_lookup_pkg::*;

  localparam int WAYS        = 8;
  localparam int SETS        = 8;
  localparam int BLOCK_BYTES = 16;
  localparam int OFF_W       = 4;
  localparam int IDX_W       = 3;
  localparam int WAY_W       = 3;
  localparam int TAG_W       = 25;
  localparam int LINE_W      = 128;

  logic              clock, reset;
  logic              valid_pre_i, ready_pre_o, valid_post_o, ready_post_i;
  logic              flush_i, csr_flush_i, inval_i, inval_busy_o;
  logic              pvalid_i, ptaken_i, pvalid_o, ptaken_o;
  logic [31:0]       ptarget_i, araddr_i, ptarget_o, araddr_o;
  logic              wen_i;
  logic [IDX_W-1:0]  windex_i;
  logic [WAY_W-1:0]  wway_i;
  logic [TAG_W-1:0]  wtag_i;
  logic [LINE_W-1:0] wdata_i;
  logic              tar_hit_o;
  logic [WAY_W-1:0]  hit_way_o, victim_o;
  logic [LINE_W-1:0] buffer_o;

  icache_lookup #(.WAYS(WAYS), .SETS(SETS), .BLOCK_BYTES(BLOCK_BYTES)) dut (
    .clock(clock), .reset(reset),
    .valid_pre_i(valid_pre_i), .ready_pre_o(ready_pre_o),
    .valid_post_o(valid_post_o), .ready_post_i(ready_post_i),
    .flush_i(flush_i), .csr_flush_i(csr_flush_i),
    .inval_i(inval_i), .inval_busy_o(inval_busy_o),
    .pvalid_i(pvalid_i), .ptaken_i(ptaken_i), .ptarget_i(ptarget_i), .araddr_i(araddr_i),
    .pvalid_o(pvalid_o), .ptaken_o(ptaken_o), .ptarget_o(ptarget_o), .araddr_o(araddr_o),
    .wen_i(wen_i), .windex_i(windex_i), .wway_i(wway_i), .wtag_i(wtag_i), .wdata_i(wdata_i),
    .tar_hit_o(tar_hit_o), .hit_way_o(hit_way_o), .buffer_o(buffer_o), .victim_o(victim_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit vpre, rpost, flush, csr, inval, wen, pvalid, ptaken;
    int widx, wway;
    logic [TAG_W-1:0]  wtag;
    logic [LINE_W-1:0] wdata;
    logic [31:0]       addr, ptarget;
  } stim_t;

  typedef struct {
    logic              pvalid, ptaken, hit;
    logic [31:0]       ptarget, araddr;
    logic [WAY_W-1:0]  way, victim;
    logic [LINE_W-1:0] data;
  } res_t;

  typedef struct {
    logic        ready_pre, valid_post, busy;
    logic [31:0] araddr;
  } ctrl_t;

  // Behavioural model: plain arrays, tree bits indexed by heap node number.
  bit                mval  [SETS][WAYS];
  logic [TAG_W-1:0]  mtag  [SETS][WAYS];
  logic [LINE_W-1:0] mdat  [SETS][WAYS];
  bit                mtree [SETS][WAYS];
  bit                mheld;
  int                minval;
  logic              mpv, mpt;
  logic [31:0]       mptarget, maddr;

  res_t  res_q[$];
  ctrl_t ctrl_q[$];
  int    total = 0;
  int    bad   = 0;

  logic [TAG_W-1:0] pool [4] = '{25'h1ABCDE, 25'h0000123, 25'h1FFFFFF, 25'h0AAAAAA};

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] addrOf(input logic [TAG_W-1:0] t, input int idx, input int off);
    return (32'(t) << (OFF_W + IDX_W)) | (32'(idx % SETS) << OFF_W) | 32'(off % BLOCK_BYTES);
  endfunction

  function automatic int setOf(input logic [31:0] a);
    return int'((a >> OFF_W) % SETS);
  endfunction

  function automatic int modelVictim(input int s);
    int node = 1;
    for (int l = 0; l < WAY_W; l++) node = 2 * node + int'(mtree[s][node]);
    return node - WAYS;
  endfunction

  function automatic void modelTouch(input int s, input int way);
    int node = 1;
    for (int l = WAY_W - 1; l >= 0; l--) begin
      int b = (way >> l) & 1;
      mtree[s][node] = (b == 0);
      node = 2 * node + b;
    end
  endfunction

  function automatic void modelLookup(input logic [31:0] a, output bit hit, output int way);
    int s = setOf(a);
    logic [TAG_W-1:0] t = TAG_W'(a >> (OFF_W + IDX_W));
    hit = 0;
    way = 0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && mval[s][w] && mtag[s][w] == t) begin
        hit = 1;
        way = w;
      end
    end
  endfunction

  function automatic void modelReset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        mval[s][w]  = 0;
        mtree[s][w] = 0;
      end
    mheld = 0; minval = 0; mpv = 0; mpt = 0; mptarget = 0; maddr = 0;
  endfunction

  function automatic stim_t idleStim();
    stim_t s;
    s.vpre = 0; s.rpost = 1; s.flush = 0; s.csr = 0; s.inval = 0; s.wen = 0;
    s.pvalid = 0; s.ptaken = 0; s.widx = 0; s.wway = 0; s.wtag = '0; s.wdata = '0;
    s.addr = '0; s.ptarget = '0;
    return s;
  endfunction

  function automatic stim_t reqStim(input logic [31:0] a, input bit rpost);
    stim_t s = idleStim();
    s.vpre = 1; s.rpost = rpost; s.addr = a;
    s.pvalid = 1'($urandom_range(1)); s.ptaken = 1'($urandom_range(1)); s.ptarget = $urandom;
    return s;
  endfunction

  function automatic stim_t refillStim(input int idx, input int way, input logic [TAG_W-1:0] t,
                                       input logic [LINE_W-1:0] d);
    stim_t s = idleStim();
    s.wen = 1; s.widx = idx; s.wway = way; s.wtag = t; s.wdata = d;
    return s;
  endfunction

  // One clock cycle: drive inputs, queue what the DUT must show this cycle,
  // then advance the model across the coming rising edge.
  task automatic applyStimulus(input stim_t s);
    ctrl_t c;
    res_t  r;
    bit    hit, fl;
    int    way, hs;
    valid_pre_i = s.vpre;  ready_post_i = s.rpost; flush_i = s.flush; csr_flush_i = s.csr;
    inval_i = s.inval;     pvalid_i = s.pvalid;    ptaken_i = s.ptaken;
    ptarget_i = s.ptarget; araddr_i = s.addr;      wen_i = s.wen;
    windex_i = IDX_W'(s.widx); wway_i = WAY_W'(s.wway); wtag_i = s.wtag; wdata_i = s.wdata;

    c.busy       = (minval > 0);
    c.valid_post = mheld;
    c.ready_pre  = c.busy ? 1'b0 : (mheld ? s.rpost : 1'b1);
    c.araddr     = maddr;
    ctrl_q.push_back(c);

    hit = 0; way = 0;
    if (mheld) modelLookup(maddr, hit, way);
    if (mheld && s.rpost) begin
      r.pvalid = mpv; r.ptaken = mpt; r.ptarget = mptarget; r.araddr = maddr;
      r.hit = hit; r.way = WAY_W'(way);
      r.data = hit ? mdat[setOf(maddr)][way] : '0;
      r.victim = WAY_W'(modelVictim(setOf(maddr)));
      res_q.push_back(r);
    end

    fl = s.flush | s.csr;
    if (minval > 0) begin
      for (int w = 0; w < WAYS; w++) begin
        mval[SETS - minval][w]  = 0;
        mtree[SETS - minval][w] = 0;
      end
      minval--;
    end else begin
      hs = setOf(maddr);
      if (mheld && s.rpost && hit && !fl && !s.inval && !(s.wen && s.widx == hs))
        modelTouch(hs, way);
      if (s.wen) begin
        mval[s.widx][s.wway] = 1;
        mtag[s.widx][s.wway] = s.wtag;
        mdat[s.widx][s.wway] = s.wdata;
        modelTouch(s.widx, s.wway);
      end
      if (s.inval || fl) begin
        mheld = 0; mpv = 0; mpt = 0; mptarget = 0; maddr = 0;
        if (s.inval) minval = SETS;
      end else if ((!mheld || s.rpost) && s.vpre) begin
        mheld = 1; mpv = s.pvalid; mpt = s.ptaken; mptarget = s.ptarget; maddr = s.addr;
      end else if (mheld && s.rpost) begin
        mheld = 0;
      end
    end
    @(posedge clock);
    #1;
  endtask

  // Monitor: compares control outputs every cycle and full results whenever
  // the DUT hands a result downstream.
  always @(negedge clock) begin : monitor
    ctrl_t c;
    res_t  r;
    if (reset) begin
      if (ctrl_q.size() > 0) begin
        c = ctrl_q.pop_front();
        checkOutput("ready_pre", 128'(ready_pre_o), 128'(c.ready_pre));
        checkOutput("valid_post", 128'(valid_post_o), 128'(c.valid_post));
        checkOutput("inval_busy", 128'(inval_busy_o), 128'(c.busy));
        checkOutput("araddr_held", 128'(araddr_o), 128'(c.araddr));
      end
      if (valid_post_o && ready_post_i) begin
        if (res_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_result actual=valid required=no_result");
        end else begin
          r = res_q.pop_front();
          checkOutput("res_araddr", 128'(araddr_o), 128'(r.araddr));
          checkOutput("res_ptarget", 128'(ptarget_o), 128'(r.ptarget));
          checkOutput("res_pvalid", 128'(pvalid_o), 128'(r.pvalid));
          checkOutput("res_ptaken", 128'(ptaken_o), 128'(r.ptaken));
          checkOutput("res_hit", 128'(tar_hit_o), 128'(r.hit));
          checkOutput("res_way", 128'(hit_way_o), 128'(r.way));
          checkOutput("res_data", 128'(buffer_o), 128'(r.data));
          checkOutput("res_victim", 128'(victim_o), 128'(r.victim));
        end
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    int    busy_cycles;
    logic [LINE_W-1:0] d;

    reset = 1'b0;
    s = idleStim();
    valid_pre_i = 0; ready_post_i = 0; flush_i = 0; csr_flush_i = 0; inval_i = 0;
    pvalid_i = 0; ptaken_i = 0; ptarget_i = 0; araddr_i = 0;
    wen_i = 0; windex_i = 0; wway_i = 0; wtag_i = 0; wdata_i = 0;
    modelReset();
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_ready_pre", 128'(ready_pre_o), 128'(1));
    checkOutput("rst_valid_post", 128'(valid_post_o), 128'(0));
    checkOutput("rst_busy", 128'(inval_busy_o), 128'(0));
    checkOutput("rst_hit", 128'(tar_hit_o), 128'(0));
    checkOutput("rst_araddr", 128'(araddr_o), 128'(0));
    checkOutput("rst_buffer", 128'(buffer_o), 128'(0));
    checkOutput("rst_victim", 128'(victim_o), 128'(0));
    reset = 1'b1;

    // Refill then hit on set 2 / way 5.
    d = 128'h0123456789ABCDEF0123456789ABCDEF;
    applyStimulus(refillStim(2, 5, 25'h1ABCDE, d));
    applyStimulus(reqStim(32'h0D5E6F20, 1));
    checkOutput("dir_hit", 128'(tar_hit_o), 128'(1));
    checkOutput("dir_way", 128'(hit_way_o), 128'(5));
    checkOutput("dir_data", buffer_o, d);
    applyStimulus(idleStim());

    // Back-to-back requests.
    applyStimulus(reqStim(addrOf(pool[1], 1, 0), 1));
    applyStimulus(reqStim(addrOf(pool[2], 4, 8), 1));
    applyStimulus(reqStim(addrOf(pool[0], 2, 4), 1));
    applyStimulus(idleStim());

    // Fill set 0, hit ways 0..6, then show the victim of set 0.
    for (int w = 0; w < WAYS; w++)
      applyStimulus(refillStim(0, w, TAG_W'(25'h100 + w), {4{$urandom}}));
    for (int w = 0; w < WAYS - 1; w++)
      applyStimulus(reqStim(addrOf(TAG_W'(25'h100 + w), 0, 0), 1));
    applyStimulus(reqStim(addrOf(pool[3], 0, 0), 1));
    applyStimulus(idleStim());

    // Hold a request, then flush it away.
    applyStimulus(reqStim(addrOf(pool[0], 2, 0), 0));
    repeat (5) begin
      s = idleStim(); s.rpost = 0; applyStimulus(s);
    end
    s = idleStim(); s.rpost = 0; s.flush = 1; applyStimulus(s);
    checkOutput("flush_valid", 128'(valid_post_o), 128'(0));
    checkOutput("flush_araddr", 128'(araddr_o), 128'(0));
    applyStimulus(idleStim());

    // Whole-cache invalidation after filling set 3.
    applyStimulus(refillStim(3, 0, pool[1], {4{$urandom}}));
    applyStimulus(refillStim(3, 1, pool[2], {4{$urandom}}));
    s = idleStim(); s.inval = 1; applyStimulus(s);
    busy_cycles = int'(inval_busy_o);
    repeat (9) begin
      applyStimulus(idleStim());
      busy_cycles += int'(inval_busy_o);
    end
    checkOutput("inval_len", 128'(busy_cycles), 128'(SETS));
    applyStimulus(reqStim(addrOf(pool[1], 3, 0), 1));
    applyStimulus(idleStim());

    // Reset in the middle of an invalidation.
    applyStimulus(refillStim(5, 2, pool[3], {4{$urandom}}));
    s = idleStim(); s.inval = 1; applyStimulus(s);
    repeat (3) applyStimulus(idleStim());
    reset = 1'b0;
    #1;
    checkOutput("midrst_busy", 128'(inval_busy_o), 128'(0));
    checkOutput("midrst_ready", 128'(ready_pre_o), 128'(1));
    modelReset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    applyStimulus(reqStim(addrOf(pool[3], 5, 0), 1));
    applyStimulus(reqStim(addrOf(pool[1], 3, 0), 1));
    applyStimulus(idleStim());

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(9) < 6)
        s = reqStim(addrOf(pool[$urandom_range(3)], $urandom_range(SETS - 1), $urandom_range(15)),
                    $urandom_range(9) < 7);
      else begin
        s = idleStim();
        s.rpost = ($urandom_range(9) < 7);
      end
      if ($urandom_range(9) < 3) begin
        s.wen = 1; s.widx = $urandom_range(SETS - 1); s.wway = $urandom_range(WAYS - 1);
        s.wtag = pool[$urandom_range(3)]; s.wdata = {4{$urandom}};
      end
      s.flush = ($urandom_range(99) < 3);
      s.csr   = ($urandom_range(99) < 2);
      s.inval = ($urandom_range(199) < 2);
      applyStimulus(s);
    end
    repeat (3) applyStimulus(idleStim());
    checkOutput("queue_drain", 128'(res_q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
